flood_reveal: RTL
=================

FLOOD_REVEAL -- requirements
Module: flood_reveal

Interface
REQ-001 Parameter GRID_W, 16, grid columns; cell address = {y[3:0], x[3:0]}.
REQ-002 Parameter GRID_H, 16, grid rows.
REQ-003 Parameter STACK_DEPTH, 256, pending-cell LIFO entries (= GRID_W*GRID_H).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to flood-reveal from seed_addr; ignored while busy.
REQ-007 seed_addr  in  8  cell selected by the play state machine.
REQ-008 abort  in  1  synchronous cancel; return to IDLE, no done pulse.
REQ-009 rd_addr  out  8  board-state read address.
REQ-010 rd_mine, rd_revealed  in  1 each  cell status, valid exactly one cycle after rd_addr.
REQ-011 rd_adj  in  4  adjacent-mine count (0..8), same timing as rd_mine.
REQ-012 reveal_wr_addr / reveal_wr_data / reveal_wr_en  out  8/1/1  reveal-memory write port; data always 1 when enabled.
REQ-013 busy  out  1  high from cycle after accepted start until done.
REQ-014 done  out  1  one-cycle pulse at completion.
REQ-015 reveal_cnt  out  9  cells written by the current run; holds until next start.

Function
REQ-016 States: IDLE, POP, RD_WAIT, CHECK, WRITE, NBR, FINISH.
REQ-017 IDLE + start: clear 256-bit queued bitmap, push seed_addr, mark it queued, reveal_cnt=0, go POP.
REQ-018 POP: stack empty -> FINISH; else pop top, drive rd_addr, go RD_WAIT.
REQ-019 RD_WAIT: one cycle for read latency, then CHECK.
REQ-020 CHECK: rd_revealed=1 or rd_mine=1 -> POP (skip); else WRITE.
REQ-021 WRITE: reveal_wr_en=1 for exactly one cycle at the popped address, reveal_cnt+1; rd_adj==0 -> NBR with index 0; else POP.
REQ-022 NBR: one neighbour per cycle, index 0..7 in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1); after index 7 -> POP.
REQ-023 Neighbour pushed only if within 0..GRID_W-1 / 0..GRID_H-1 (no wrap-around at edges) and its queued bit is 0; the push sets the queued bit.
REQ-024 Queued bitmap bounds stack occupancy at 256; stack full with a pending push is unreachable; the bench asserts it never occurs.
REQ-025 FINISH: done=1 for one cycle, busy=0, go IDLE.
REQ-026 Timing: revealed/mine seed -> done 4 cycles after start; single nonzero-count seed -> 5 cycles; each zero cell adds 8 NBR cycles.
REQ-027 start while busy: ignored, no effect on the run in progress.
REQ-028 abort overrides every state including WRITE (no write that cycle); abort and start in the same IDLE cycle: abort wins.
REQ-029 reveal_wr_en never asserted outside WRITE; rd_addr holds last value when idle.
REQ-030 Mine cells are never written; a mine seed yields done with reveal_cnt=0 (loss detection belongs to play state, not this block).

Reset
REQ-031 rst=1 forces immediately: state IDLE, busy=0, done=0, reveal_wr_en=0, reveal_wr_data=0, reveal_wr_addr=0, rd_addr=0, reveal_cnt=0, stack pointer 0, queued bitmap all 0.
REQ-032 Reset mid-run abandons the run; no done pulse; stack contents are don't-care.

Structure
REQ-033 Shared package minesweeper_pkg holds GRID_W, GRID_H, cell address width, state enum, neighbour dx/dy table.
REQ-034 One sub-module cell_stack: synchronous LIFO, 8-bit data, STACK_DEPTH entries, push/pop/empty/full, 9-bit pointer.
REQ-035 Top-level reveal-write mux gives start_3x3 priority over flood_reveal, flood_reveal priority over play_state.

Verification
REQ-036 Seed 0x55 with rd_revealed=1 -> no write, done at cycle 4, reveal_cnt=0.
REQ-037 Seed 0x00 with adj=2 -> single write to 0x00, reveal_cnt=1, done at cycle 5.
REQ-038 Empty board, no mines, seed 0x88 -> all 256 cells written once each, reveal_cnt=256, no duplicate addresses.
REQ-039 Corner seed 0xFF, zero-count, neighbours nonzero -> writes to 0xFF,0xFE,0xEF,0xEE only; no wrap to x=0 or y=0.
REQ-040 Mine ring enclosing 0x44..0x46 rows 4..6, seed 0x55 -> writes stop at ring boundary, no mine cell written.
REQ-041 rst asserted mid-run after 10 writes -> outputs at reset values same cycle; new start runs normally with cleared bitmap.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: grid geometry, flood-reveal state codes and neighbour offset table.
package minesweeper_pkg;
  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int ADDR_W = 8;
  localparam int CELLS  = GRID_W * GRID_H;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_POP     = 3'd1;
  localparam state_t S_RD_WAIT = 3'd2;
  localparam state_t S_CHECK   = 3'd3;
  localparam state_t S_WRITE   = 3'd4;
  localparam state_t S_NBR     = 3'd5;
  localparam state_t S_FINISH  = 3'd6;
  // 2-bit signed offsets per neighbour index, index 0 in the low bits
  localparam logic [15:0] NBR_DX = 16'b01_00_11_01_11_01_00_11;
  localparam logic [15:0] NBR_DY = 16'b01_01_01_00_00_11_11_11;
  function automatic logic [ADDR_W:0] nbr_of(input logic [ADDR_W-1:0] a, input logic [2:0] k,
                                             input int w, input int h);
    int x, y;
    x = int'(a[3:0]) + int'($signed(NBR_DX[2*k +: 2]));
    y = int'(a[7:4]) + int'($signed(NBR_DY[2*k +: 2]));
    return {x >= 0 && x < w && y >= 0 && y < h, 4'(y), 4'(x)};
  endfunction
endpackage

// File: rtl/cell_stack.sv
// cell_stack: synchronous LIFO of pending cell addresses; clr restarts it at the bottom entry.
module cell_stack #(
  parameter int DEPTH = 256,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_base;
  assign w_base = clr ? '0 : r_ptr;
  assign dout   = r_mem[IW'(r_ptr - PW'(1))];
  assign empty  = r_ptr == '0;
  assign full   = r_ptr == PW'(DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_base + PW'(push) - PW'(pop);
  always_ff @(posedge clk)
    if (push) r_mem[IW'(w_base)] <= din;
endmodule

// File: rtl/flood_reveal.sv
// flood_reveal: iterative zero-cell flood reveal over a GRID_W x GRID_H board using a LIFO
// and a queued bitmap so every cell is pushed at most once per run.
module flood_reveal
  import minesweeper_pkg::*;
#(
  parameter int GRID_W      = minesweeper_pkg::GRID_W,
  parameter int GRID_H      = minesweeper_pkg::GRID_H,
  parameter int STACK_DEPTH = minesweeper_pkg::CELLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed_addr,
  input  logic       abort,
  output logic [7:0] rd_addr,
  input  logic       rd_mine,
  input  logic       rd_revealed,
  input  logic [3:0] rd_adj,
  output logic [7:0] reveal_wr_addr,
  output logic       reveal_wr_data,
  output logic       reveal_wr_en,
  output logic       busy,
  output logic       done,
  output logic [8:0] reveal_cnt
);
  state_t                 r_state;
  logic [7:0]             r_cur;
  logic [7:0]             r_rd_addr;
  logic [2:0]             r_nbr;
  logic                   r_adj_zero;
  logic [8:0]             r_cnt;
  logic [STACK_DEPTH-1:0] r_queued;
  logic [8:0]             w_nb;
  logic [7:0]             w_top;
  logic [7:0]             w_din;
  logic                   w_take;
  logic                   w_nb_push;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  assign w_take     = r_state == S_IDLE && start && !abort;
  assign w_nb       = nbr_of(r_cur, r_nbr, GRID_W, GRID_H);
  assign w_nb_push  = r_state == S_NBR && w_nb[8] && !r_queued[w_nb[7:0]];
  assign w_push_req = w_take || (w_nb_push && !abort);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = r_state == S_POP && !w_empty && !abort;
  assign w_din      = w_take ? seed_addr : w_nb[7:0];
  assign rd_addr        = r_rd_addr;
  assign reveal_wr_addr = r_cur;
  assign reveal_wr_en   = r_state == S_WRITE && !abort;
  assign reveal_wr_data = reveal_wr_en;
  assign busy           = r_state != S_IDLE && r_state != S_FINISH;
  assign done           = r_state == S_FINISH;
  assign reveal_cnt     = r_cnt;
  cell_stack #(.DEPTH(STACK_DEPTH), .W(8)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_take),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_top),
    .empty (w_empty),
    .full  (w_full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_rd_addr  <= '0;
      r_nbr      <= '0;
      r_adj_zero <= 1'b0;
      r_cnt      <= '0;
      r_queued   <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_queued            <= '0;
          r_queued[seed_addr] <= 1'b1;
          r_cnt               <= '0;
          r_state             <= S_POP;
        end
        S_POP: begin
          if (!w_empty) begin
            r_rd_addr <= w_top;
            r_cur     <= w_top;
          end
          r_state <= w_empty ? S_FINISH : S_RD_WAIT;
        end
        S_RD_WAIT: r_state <= S_CHECK;
        // board data for r_cur is valid only now, so the zero test is captured for WRITE
        S_CHECK: begin
          r_adj_zero <= rd_adj == 4'd0;
          r_state    <= (rd_revealed || rd_mine) ? S_POP : S_WRITE;
        end
        S_WRITE: begin
          r_cnt   <= r_cnt + 9'd1;
          r_nbr   <= '0;
          r_state <= r_adj_zero ? S_NBR : S_POP;
        end
        S_NBR: begin
          if (w_push) r_queued[w_nb[7:0]] <= 1'b1;
          r_nbr   <= r_nbr + 3'd1;
          r_state <= r_nbr == 3'd7 ? S_POP : S_NBR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule
